// File: rtl/comp_rr_sched_if.sv
// Requester-fabric bundle for comp_rr_sched.
// The master modport is the requester side. It drives the operation requests and
// samples the grants and responses. The slave modport is the scheduler side.
interface comp_rr_sched_if #(
    parameter int p_size = 1,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*p_size-1:0] req_a;
    logic [N_REQ*p_size-1:0] req_b;
    logic [N_REQ-1:0]        rsp_valid;
    logic [2*p_size-1:0]     rsp_data;
    logic [2*p_size-1:0]     rsp_data_2;
    logic                    rsp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, rsp_data_2, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, rsp_data_2, rsp_err
    );
endinterface

// File: rtl/comp_rr_sched.sv
// Round-robin scheduler sharing one comp datapath between N_REQ requesters.
// A single operation is in flight at any time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature: define COMP_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles without dv. The aborted operation returns rsp_err=1 and zero data.
module comp_rr_sched #(
    parameter int p_size  = 1,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    comp_rr_sched_if.slave      req,
    output logic                busy,
    output logic                c_ena,
    output logic [p_size-1:0]   c_i_param,
    output logic [p_size-1:0]   c_i_param_2,
    input  logic [2*p_size-1:0] c_o_param,
    input  logic [2*p_size-1:0] c_o_param_2,
    input  logic                c_dv
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2) begin : g_bad_nreq
        $error("comp_rr_sched: N_REQ must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("comp_rr_sched: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [p_size-1:0]     a_q, a_d, b_q, b_d;
    logic [2*p_size-1:0]   d_q, d_d, d2_q, d2_d;
    logic [IW-1:0]         win;
    logic                  win_vld;
    logic [IW-1:0]         cand;
    int unsigned           idx;
`ifdef COMP_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
`endif

    // Round-robin winner: first valid requester scanning upward from ptr+1 with wrap
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx  = (32'(ptr_q) + k) % 32'(N_REQ);
            cand = IW'(idx);
            if (!win_vld && req.req_valid[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    // Grant is combinational in IDLE; it is masked while reset is held so every output reads 0
    always_comb begin
        req.req_ready = '0;
        if (rst && state_q == S_IDLE && win_vld) begin
            req.req_ready[win] = 1'b1;
        end
    end

    // Next-state logic: accept, single-cycle issue, wait for dv (or timeout), respond
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        d2_d    = d2_q;
`ifdef COMP_SCHED_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d   = win;
                    a_d     = req.req_a[win*p_size +: p_size];
                    b_d     = req.req_b[win*p_size +: p_size];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef COMP_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (c_dv) begin
                    d_d     = c_o_param;
                    d2_d    = c_o_param_2;
`ifdef COMP_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef COMP_SCHED_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) begin
                        d_d     = '0;
                        d2_d    = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
`endif
            end
            S_RESP: begin
                ptr_d   = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset leaves ptr at N_REQ-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            d2_q    <= '0;
`ifdef COMP_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            d2_q    <= d2_d;
`ifdef COMP_SCHED_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs decoded from state; response fields are forced to 0 outside RESP
    always_comb begin
        busy           = (state_q != S_IDLE);
        c_ena          = (state_q == S_ISSUE);
        c_i_param      = (state_q != S_IDLE) ? a_q : '0;
        c_i_param_2    = (state_q != S_IDLE) ? b_q : '0;
        req.rsp_valid  = '0;
        req.rsp_data   = '0;
        req.rsp_data_2 = '0;
        req.rsp_err    = 1'b0;
        if (state_q == S_RESP) begin
            req.rsp_valid[gnt_q] = 1'b1;
            req.rsp_data         = d_q;
            req.rsp_data_2       = d2_q;
`ifdef COMP_SCHED_TIMEOUT_EN
            req.rsp_err          = err_q;
`endif
        end
    end
endmodule

// File: tb/tb_comp_rr_sched.sv
// Self-checking bench for comp_rr_sched (p_size=4, N_REQ=4, TIMEOUT=8).
// The comp stand-in is a multiplier with latency 2 and o_param_2 = a+b.
// The reference model tracks each operation by cycle numbers: the accept cycle,
// the issue cycle one later, waiting from two cycles on, and the response one
// cycle after dv or after the timeout.
module tb_comp_rr_sched;
    localparam int P  = 4;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, c_ena, c_dv;
    logic [P-1:0]   c_i_param, c_i_param_2;
    logic [2*P-1:0] c_o_param, c_o_param_2;

    comp_rr_sched_if #(.p_size(P), .N_REQ(N)) bus();

    comp_rr_sched #(.p_size(P), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(bus), .busy(busy), .c_ena(c_ena),
        .c_i_param(c_i_param), .c_i_param_2(c_i_param_2),
        .c_o_param(c_o_param), .c_o_param_2(c_o_param_2), .c_dv(c_dv)
    );

    always #5 clk = ~clk;

    // comp stand-in: latency 2; outputs garbage when dv is low
    logic p1 = 1'b0, p2 = 1'b0, comp_mute = 1'b0;
    logic ovr_dv = 1'b0;
    logic [7:0] ovr_p = '0, ovr_p2 = '0, res = '0, res2 = '0, junk = '0, junk2 = '0;
    logic model_dv;
    always @(posedge clk) begin
        p1 <= c_ena;
        p2 <= p1;
        if (c_ena) begin
            res  <= {4'b0, c_i_param} * {4'b0, c_i_param_2};
            res2 <= {4'b0, c_i_param} + {4'b0, c_i_param_2};
        end
        junk  <= 8'($urandom);
        junk2 <= 8'($urandom);
    end
    assign model_dv    = p2 & ~comp_mute;
    assign c_dv        = model_dv | ovr_dv;
    assign c_o_param   = ovr_dv ? ovr_p  : (model_dv ? res  : junk);
    assign c_o_param_2 = ovr_dv ? ovr_p2 : (model_dv ? res2 : junk2);

    logic [26:0] act_vec;
    assign act_vec = {bus.req_ready, c_ena, bus.rsp_valid, bus.rsp_data, bus.rsp_data_2, bus.rsp_err, busy};

    int tests_run = 0, tests_failed = 0;
    int cyc = 0;

    // reference model state
    bit         m_busy;
    int         m_ptr, m_g, m_acc, m_rsp_cyc, m_miss;
    logic [3:0] m_a, m_b;
    logic [7:0] m_d, m_d2;
    bit         m_err;
    logic [26:0] exp_vec;
    logic [7:0]  exp_ops;
    bit          chk_ops, acc_now;
    int          acc_g;

    function automatic int winner(input logic [3:0] v, input int ptr);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ptr = N - 1; m_rsp_cyc = -1; m_miss = 0; m_acc = -10;
    endtask

    // One clock cycle: drive inputs at negedge, form expectations, advance the model
    task automatic cycle(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b, input bit dvp);
        int w;
        logic [3:0] rdy, rv;
        @(negedge clk);
        bus.req_valid = v; bus.req_a = a; bus.req_b = b;
        ovr_dv = dvp; ovr_p = 8'($urandom); ovr_p2 = 8'($urandom);
        #1;
        cyc++;
        rdy = '0; w = -1;
        if (!m_busy) begin
            w = winner(v, m_ptr);
            if (w >= 0) rdy[w[1:0]] = 1'b1;
        end
        rv = '0;
        if (m_busy && cyc == m_rsp_cyc) rv[m_g[1:0]] = 1'b1;
        exp_vec = {rdy, m_busy && cyc == m_acc + 1, rv, (rv != 0) ? m_d : 8'h0,
                   (rv != 0) ? m_d2 : 8'h0, (rv != 0) && m_err, m_busy && cyc > m_acc};
        chk_ops = m_busy && cyc > m_acc;
        exp_ops = {m_a, m_b};
        acc_now = 0;
        if (m_busy) begin
            if (cyc == m_rsp_cyc) begin
                m_ptr = m_g; m_busy = 0;
            end else if (cyc >= m_acc + 2 && m_rsp_cyc < 0) begin
                if (c_dv) begin
                    m_rsp_cyc = cyc + 1; m_d = c_o_param; m_d2 = c_o_param_2; m_err = 0;
                end else begin
                    m_miss++;
`ifdef COMP_SCHED_TIMEOUT_EN
                    if (m_miss == TO) begin
                        m_rsp_cyc = cyc + 1; m_d = '0; m_d2 = '0; m_err = 1;
                    end
`endif
                end
            end
        end else if (w >= 0) begin
            m_busy = 1; m_g = w; m_acc = cyc; m_rsp_cyc = -1; m_miss = 0;
            m_a = a[w*4 +: 4]; m_b = b[w*4 +: 4];
            acc_now = 1; acc_g = w;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_valid = 4'($urandom); bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
            ovr_dv = 1'($urandom);
            #1;
            tests_run++;
            if ({act_vec, c_i_param, c_i_param_2} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs got=%h req=0", {act_vec, c_i_param, c_i_param_2});
            end
        end
        @(negedge clk);
        bus.req_valid = '0; ovr_dv = 1'b0;
        rst = 1'b1;
        model_reset();
        cycle(4'b1111, 16'($urandom), 16'($urandom), 0);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant got=%b req=0001", bus.req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0000, '0, '0, 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL reset_drain cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_op();
        int t0;
        cycle(4'b0010, 16'h0030, 16'h0050, 0);
        t0 = cyc;
        tests_run++;
        if (bus.req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL single_grant got=%b req=0010", bus.req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0000, 16'($urandom), 16'($urandom), 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (cyc == t0 + 1) begin
                tests_run++;
                if ({c_ena, c_i_param, c_i_param_2} !== {1'b1, 4'd3, 4'd5}) begin
                    tests_failed++;
                    $display("FAIL single_issue got=%h req=%h", {c_ena, c_i_param, c_i_param_2}, {1'b1, 4'd3, 4'd5});
                end
            end
            if (cyc == t0 + 4) begin
                tests_run++;
                if ({bus.rsp_valid, bus.rsp_data, bus.rsp_data_2} !== {4'b0010, 8'd15, 8'd8}) begin
                    tests_failed++;
                    $display("FAIL single_rsp got=%h req=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_data_2}, {4'b0010, 8'd15, 8'd8});
                end
            end
        end
    endtask

    task automatic test_fairness();
        int order[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
        int ng = 0, last = 0, gi;
        logic [3:0] v, obs;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; model_reset();
        for (int i = 0; i < 80 && ng < 9; i++) begin
            v = (ng >= 6) ? 4'b1010 : 4'b1111;
            cycle(v, 16'($urandom), 16'($urandom), 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL fair_model cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            obs = bus.req_ready & v;
            if (obs != 0) begin
                gi = -1;
                for (int j = 0; j < 4; j++) if (obs[j]) gi = j;
                tests_run++;
                if (gi != order[ng] || (ng > 0 && cyc - last != 5)) begin
                    tests_failed++;
                    $display("FAIL fair_order n=%0d got=%0d/%0d req=%0d/5", ng, gi, cyc - last, order[ng]);
                end
                last = cyc; ng++;
            end
        end
        tests_run++;
        if (ng != 9) begin
            tests_failed++;
            $display("FAIL fair_count got=%0d req=9", ng);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0000, '0, '0, 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL fair_drain cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_timeout();
        int t0;
        logic [7:0] sp, sp2;
        comp_mute = 1'b1;
        cycle(4'b0100, 16'($urandom), 16'($urandom), 0);
        t0 = cyc;
`ifdef COMP_SCHED_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            cycle(4'b0000, '0, '0, 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (cyc == t0 + 2 + TO) begin
                tests_run++;
                if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_data_2} !== {4'b0100, 1'b1, 16'h0}) begin
                    tests_failed++;
                    $display("FAIL timeout_rsp got=%h req=%h", {bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_data_2}, {4'b0100, 1'b1, 16'h0});
                end
            end
        end
`else
        for (int i = 0; i < 30; i++) begin
            cycle(4'b0000, '0, '0, 0);
            tests_run++;
            if (act_vec !== exp_vec || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL notimeout_hold cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
        cycle(4'b0000, '0, '0, 1);
        sp = ovr_p; sp2 = ovr_p2;
        cycle(4'b0000, '0, '0, 0);
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_data_2} !== {4'b0100, 1'b0, sp, sp2}) begin
            tests_failed++;
            $display("FAIL notimeout_rsp got=%h req=%h", {bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_data_2}, {4'b0100, 1'b0, sp, sp2});
        end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000, '0, '0, 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL notimeout_drain cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
`endif
        comp_mute = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        comp_mute = 1'b1;
        cycle(4'b1000, 16'($urandom), 16'($urandom), 0);
        for (int i = 0; i < 3; i++) cycle(4'b0000, '0, '0, 0);
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if ({act_vec, c_i_param, c_i_param_2} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got=%h req=0", {act_vec, c_i_param, c_i_param_2});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0000, '0, '0, (i < 2));
            tests_run++;
            if (act_vec !== exp_vec || bus.rsp_valid !== 4'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_late_dv cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
        comp_mute = 1'b0;
        cycle(4'b1111, 16'($urandom), 16'($urandom), 0);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midreset_grant got=%b req=0001", bus.req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0000, '0, '0, 0);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL midreset_drain cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_stray_dv();
        int t0;
        logic [3:0] a, b;
        for (int i = 0; i < 2; i++) begin
            cycle(4'b0000, '0, '0, 1);
            tests_run++;
            if (act_vec !== exp_vec || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL stray_idle cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
        a = 4'($urandom); b = 4'($urandom);
        cycle(4'b0001, {12'h0, a}, {12'h0, b}, 0);
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0000, '0, '0, (i == 0));
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL stray_model cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (cyc == t0 + 4) begin
                tests_run++;
                if ({bus.rsp_valid, bus.rsp_data, bus.rsp_data_2} !== {4'b0001, 8'(a * b), 8'(a + b)}) begin
                    tests_failed++;
                    $display("FAIL stray_rsp got=%h req=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_data_2}, {4'b0001, 8'(a * b), 8'(a + b)});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 19) == 0));
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (chk_ops) begin
                tests_run++;
                if ({c_i_param, c_i_param_2} !== exp_ops) begin
                    tests_failed++;
                    $display("FAIL random_ops cyc=%0d got=%h exp=%h", cyc, {c_i_param, c_i_param_2}, exp_ops);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        model_reset();
        test_reset();
        test_single_op();
        test_fairness();
        test_timeout();
        test_reset_mid_op();
        test_stray_dv();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, tests_failed=%0d", tests_failed);
        $fatal(1, "watchdog");
    end
endmodule
